// File: rtl/regfile_write_controller_pkg.sv
// Shared encodings for the register-file write side: write codes and the R0 index.
package regfile_write_controller_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  // registerWrite encodings; 2'b11 is never driven
  typedef enum logic [1:0] {
    WR_NONE  = 2'b00,
    WR_LOCAL = 2'b01,
    WR_R0    = 2'b10
  } wr_code_e;

  localparam logic [3:0] REG_R0 = 4'h0;
endpackage

// File: rtl/regfile_write_controller_wb_fifo.sv
// ALU result FIFO of {dest,data}. Entries are exposed oldest-first with valid bits
// so the top can search them for forwarding and R0 ordering.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_dest,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_dest,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                   wr_ptr, rd_ptr, count;
  logic [DEPTH-1:0][ADDR_W-1:0]  mem_dest;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_data;

  // extra wrap bit distinguishes full from empty when the index bits match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // age-ordered view: entry 0 is the head
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] idx;
    assign idx         = rd_ptr[AW-1:0] + AW'(i);
    assign ent_dest[i] = mem_dest[idx];
    assign ent_data[i] = mem_data[idx];
    assign ent_vld[i]  = (count > (AW+1)'(i));
  end

  // pointer and storage update; index bits wrap naturally at DEPTH-1 -> 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_dest <= '0;
      mem_data <= '0;
    end else begin
      if (push && !full) begin
        mem_dest[wr_ptr[AW-1:0]] <= push_dest;
        mem_data[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_write_controller.sv
// Register-file write initiator: buffers ALU and mult/div results, issues one write
// per cycle, and forwards pending (uncommitted) values to decode.
module regfile_write_controller
  import regfile_write_controller_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              md_valid,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic [1:0]        registerWrite,
  output logic [ADDR_W-1:0] regWriteLocal,
  output logic [DATA_W-1:0] dataWrite,
  output logic [DATA_W-1:0] r0Write,
  input  logic [ADDR_W-1:0] fwd_reg,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              idle
);
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_R0);

  logic                         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic                         r0_held, pri_r0, md_push;
  logic [DATA_W-1:0]            r0_data;
  logic                         fifo_has_r0, out_has_r0, contested, issue_r0, issue_fifo;

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_dest (alu_dest),
    .push_data (alu_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_vld   (ent_vld),
    .ent_dest  (ent_dest),
    .ent_data  (ent_data)
  );

  // any queued ALU write to R0 blocks a new md result, keeping R0 writes in order
  always_comb begin
    fifo_has_r0 = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i] && ent_dest[i] == R0) fifo_has_r0 = 1'b1;
  end

  assign out_has_r0 = (registerWrite == WR_LOCAL) && (regWriteLocal == R0);
  assign alu_ready  = !fifo_full && !(alu_dest == R0 && r0_held);
  assign md_ready   = !r0_held && !fifo_has_r0 && !out_has_r0;
  assign fifo_push  = alu_valid && alu_ready;
  assign md_push    = md_valid && md_ready;

  // pri_r0 set: R0 holding wins a contested cycle; cleared after every R0 issue
  assign contested  = r0_held && !fifo_empty;
  assign issue_r0   = r0_held && (fifo_empty || pri_r0);
  assign issue_fifo = !fifo_empty && !issue_r0;
  assign fifo_pop   = issue_fifo;

  assign idle = fifo_empty && !r0_held && (registerWrite == WR_NONE);

  // output stage, R0 holding register and arbitration priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      registerWrite <= WR_NONE;
      regWriteLocal <= '0;
      dataWrite     <= '0;
      r0Write       <= '0;
      r0_held       <= 1'b0;
      r0_data       <= '0;
      pri_r0        <= 1'b1;
    end else begin
      if (issue_r0) begin
        registerWrite <= WR_R0;
        r0Write       <= r0_data;
      end else if (issue_fifo) begin
        registerWrite <= WR_LOCAL;
        regWriteLocal <= ent_dest[0];
        dataWrite     <= ent_data[0];
      end else begin
        registerWrite <= WR_NONE;
      end
      if (issue_r0)       pri_r0 <= 1'b0;
      else if (contested) pri_r0 <= 1'b1;
      if (md_push) begin
        r0_held <= 1'b1;
        r0_data <= md_data;
      end else if (issue_r0) begin
        r0_held <= 1'b0;
      end
    end
  end

  // forwarding: scan oldest to newest (output stage, FIFO, R0 holding), last match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (registerWrite == WR_LOCAL && regWriteLocal == fwd_reg) begin
      fwd_hit  = 1'b1;
      fwd_data = dataWrite;
    end
    if (registerWrite == WR_R0 && fwd_reg == R0) begin
      fwd_hit  = 1'b1;
      fwd_data = r0Write;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_dest[i] == fwd_reg) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[i];
      end
    end
    if (r0_held && fwd_reg == R0) begin
      fwd_hit  = 1'b1;
      fwd_data = r0_data;
    end
  end
endmodule

// File: tb/tb_regfile_write_controller.sv
// Bench for regfile_write_controller: queue-based reference model checked every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_regfile_write_controller;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [15:0] alu_data = '0;
  logic        alu_ready;
  logic        md_valid = 1'b0;
  logic [15:0] md_data = '0;
  logic        md_ready;
  logic [1:0]  registerWrite;
  logic [3:0]  regWriteLocal;
  logic [15:0] dataWrite, r0Write;
  logic [3:0]  fwd_reg = '0;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_controller dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_data(md_data), .md_ready(md_ready),
    .registerWrite(registerWrite), .regWriteLocal(regWriteLocal),
    .dataWrite(dataWrite), .r0Write(r0Write),
    .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .idle(idle)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] r; logic [15:0] d; int sq; } wr_t;
  wr_t         aq[$];          // accepted ALU results not yet issued
  wr_t         rhe, os;        // R0 holding value, value on the outputs
  bit          rh = 0;         // R0 holding occupied
  bit          pri = 1;        // R0 preferred on the next contested cycle
  int          sq = 0;         // acceptance sequence number (age)
  logic [1:0]  m_rw = 0;
  logic [3:0]  m_idx = 0;
  logic [15:0] m_dw = 0, m_r0 = 0;

  function automatic bit m_alu_ready();
    return aq.size() < 4 && !(alu_dest == 0 && rh);
  endfunction

  function automatic bit m_md_ready();
    if (rh) return 0;
    if (m_rw == 2'b01 && m_idx == 0) return 0;
    foreach (aq[i]) if (aq[i].r == 0) return 0;
    return 1;
  endfunction

  // newest accepted, uncommitted value for fwd_reg by acceptance age
  task automatic m_fwd(output bit h, output logic [15:0] d);
    int best = -1;
    h = 0; d = 0;
    if (m_rw != 0 && os.r == fwd_reg) begin best = os.sq; h = 1; d = os.d; end
    foreach (aq[i]) if (aq[i].r == fwd_reg && aq[i].sq > best) begin best = aq[i].sq; h = 1; d = aq[i].d; end
    if (rh && fwd_reg == 0 && rhe.sq > best) begin h = 1; d = rhe.d; end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      aq.delete(); rh = 0; pri = 1;
      m_rw = 0; m_idx = 0; m_dw = 0; m_r0 = 0;
    end else begin
      bit a_acc, m_acc;
      a_acc = alu_valid && m_alu_ready();
      m_acc = md_valid && m_md_ready();
      if (rh && (aq.size() == 0 || pri)) begin
        os = rhe; rh = 0; pri = 0; m_rw = 2'b10; m_r0 = os.d;
      end else if (aq.size() > 0) begin
        if (rh) pri = 1;
        os = aq.pop_front(); m_rw = 2'b01; m_idx = os.r; m_dw = os.d;
      end else begin
        m_rw = 2'b00;
      end
      if (a_acc) begin aq.push_back('{alu_dest, alu_data, sq}); sq++; end
      if (m_acc) begin rhe = '{4'd0, md_data, sq}; sq++; rh = 1; end
    end
  end

  // ---------------- per-cycle compare + observed write log ----------------
  typedef struct { logic [1:0] rw; logic [3:0] r; logic [15:0] d; } log_t;
  log_t dut_log[$];

  initial forever begin
    bit          eh;
    logic [15:0] ed;
    @(negedge clk);
    m_fwd(eh, ed);
    chk("registerWrite", registerWrite, m_rw);
    chk("regWriteLocal", regWriteLocal, m_idx);
    chk("dataWrite", dataWrite, m_dw);
    chk("r0Write", r0Write, m_r0);
    chk("alu_ready", alu_ready, m_alu_ready());
    chk("md_ready", md_ready, m_md_ready());
    chk("idle", idle, aq.size() == 0 && !rh && m_rw == 0);
    chk("fwd_hit", fwd_hit, eh);
    chk("fwd_data", fwd_data, ed);
    if (registerWrite != 2'b00)
      dut_log.push_back('{registerWrite, (registerWrite == 2'b01) ? regWriteLocal : 4'd0,
                          (registerWrite == 2'b01) ? dataWrite : r0Write});
  end

  // ---------------- stimulus helpers ----------------
  typedef struct { logic [3:0] r; logic [15:0] d; } vec_t;
  vec_t        asrc[$];
  logic [15:0] msrc[$];
  int          stall_cnt = 0;
  bit          sweep = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // offer queued ALU/md results every cycle until all are accepted
  task automatic pump();
    int c = 0;
    while (asrc.size() > 0 || msrc.size() > 0) begin
      bit a_ok, m_ok;
      if (sweep) fwd_reg = fwd_reg + 4'd1;
      alu_valid = asrc.size() > 0;
      if (alu_valid) begin alu_dest = asrc[0].r; alu_data = asrc[0].d; end
      md_valid = msrc.size() > 0;
      if (md_valid) md_data = msrc[0];
      @(negedge clk);
      a_ok = alu_valid && alu_ready;
      m_ok = md_valid && md_ready;
      if (alu_valid && !alu_ready && alu_dest != 0) stall_cnt++;
      @(posedge clk); #1;
      if (a_ok) void'(asrc.pop_front());
      if (m_ok) void'(msrc.pop_front());
      alu_valid = 0; md_valid = 0;
      if (++c > 300) begin
        total++; bad++;
        $display("FAIL pump_timeout: %0d alu / %0d md left after %0d cycles", asrc.size(), msrc.size(), c);
        asrc.delete(); msrc.delete();
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int l3, l4, l6, r0n, alun, errs, inter;
    #1 reset_n = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("t1_rst_rw", registerWrite, 0);
    chk("t1_rst_idle", idle, 1);
    chk("t1_rst_r0w", r0Write, 0);
    #2 reset_n = 1;
    for (int r = 0; r < 16; r++) begin
      fwd_reg = 4'(r); #1;
      chk("t1_fwd_miss", fwd_hit, 0);
    end
    tick(1);
    chk("t1_idle", idle, 1);

    // single ALU write: accepted at N, on outputs after N+1, gone after N+2
    fwd_reg = 3;
    asrc.push_back('{4'd3, 16'd4020});
    pump();
    chk("t2_rw_before", registerWrite, 0);
    chk("t2_pend_hit", fwd_hit, 1);
    chk("t2_pend_data", fwd_data, 4020);
    tick(1);
    chk("t2_rw", registerWrite, 1);
    chk("t2_idx", regWriteLocal, 3);
    chk("t2_data", dataWrite, 4020);
    chk("t2_out_hit", fwd_data, 4020);
    tick(1);
    chk("t2_rw_after", registerWrite, 0);
    chk("t2_hit_after", fwd_hit, 0);

    // md to R0 then an ALU R0 write that must wait
    fwd_reg = 0;
    l3 = dut_log.size();
    msrc.push_back(16'd1239);
    pump();
    alu_valid = 1; alu_dest = 0; alu_data = 16'd5555; #1;
    chk("t3_alu_held_off", alu_ready, 0);
    chk("t3_fwd_r0", fwd_data, 1239);
    alu_valid = 0;
    asrc.push_back('{4'd0, 16'd5555});
    pump();
    tick(4);
    chk("t3_r0_count", dut_log.size() - l3, 2);
    if (dut_log.size() - l3 == 2) begin
      chk("t3_first_code", dut_log[l3].rw, 2);
      chk("t3_first", dut_log[l3].d, 1239);
      chk("t3_second_code", dut_log[l3+1].rw, 1);
      chk("t3_second", dut_log[l3+1].d, 5555);
    end

    // 12 ALU results back-to-back with 6 md results contending
    l4 = dut_log.size();
    stall_cnt = 0;
    for (int i = 0; i < 12; i++) asrc.push_back('{4'((i % 15) + 1), 16'(100 + i)});
    for (int i = 0; i < 6; i++) msrc.push_back(16'(7000 + i));
    sweep = 1;
    pump();
    sweep = 0;
    tick(10);
    chk("t4_alu_stalled", stall_cnt > 0, 1);
    r0n = 0; alun = 0; errs = 0; inter = 0;
    for (int i = l4; i < dut_log.size(); i++) begin
      if (dut_log[i].rw == 2) begin
        if (dut_log[i].d != 16'(7000 + r0n)) errs++;
        r0n++;
        if (i + 1 < dut_log.size() && dut_log[i+1].rw == 1 && alun > 0 && alun < 12) inter++;
      end else begin
        if (dut_log[i].d != 16'(100 + alun) || dut_log[i].r != 4'((alun % 15) + 1)) errs++;
        alun++;
      end
    end
    chk("t4_alu_count", alun, 12);
    chk("t4_r0_count", r0n, 6);
    chk("t4_order_errs", errs, 0);
    chk("t4_interleave", inter > 0, 1);
    chk("t4_idle", idle, 1);

    // two pending writes to r5: newest forwards
    fwd_reg = 5;
    asrc.push_back('{4'd5, 16'd1111});
    asrc.push_back('{4'd5, 16'd2222});
    pump();
    chk("t5_hit", fwd_hit, 1);
    chk("t5_newest", fwd_data, 2222);
    tick(3);
    chk("t5_hit_after", fwd_hit, 0);
    chk("t5_data_after", fwd_data, 0);

    // async reset with several writes pending
    fwd_reg = 2;
    asrc.push_back('{4'd1, 16'd11});
    asrc.push_back('{4'd2, 16'd22});
    asrc.push_back('{4'd4, 16'd44});
    msrc.push_back(16'd99);
    pump();
    chk("t6_busy", idle, 0);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_rw", registerWrite, 0);
    chk("t6_rst_idx", regWriteLocal, 0);
    chk("t6_rst_dw", dataWrite, 0);
    chk("t6_rst_r0w", r0Write, 0);
    chk("t6_rst_idle", idle, 1);
    chk("t6_rst_fwd", fwd_hit, 0);
    @(posedge clk); #1 reset_n = 1;
    l6 = dut_log.size();
    tick(5);
    chk("t6_no_writes", dut_log.size() - l6, 0);
    chk("t6_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
